axi_mctp_wr_slave: RTL

//  AXI4 write-channel responder for MCTP-over-PCIe VDM writes (256b data).
//  - Accepts one AW/W burst at a time; beat 0 carries a 128b TLP header in WDATA[127:0].
//  - Checks MCTP packet assembly order, forwards accepted beats on a valid/ready payload stream.
//  - Returns B with OKAY or SLVERR. Sits between the AXI interconnect and the MCTP reassembly buffer.

---
 rtl/mctp_pkg.sv | 41 ++++
 rtl/mctp_asm_check.sv | 71 +++++++
 rtl/axi_mctp_wr_slave.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mctp_pkg.sv
// Shared definitions for the MCTP-over-PCIe VDM write responder:
// packet type codes, header bit positions, tag/seq widths and AXI response codes.
package mctp_pkg;

   // MCTP packet position within a message, as carried in hdr[127:126]
   typedef enum logic [1:0] {
      PKT_M  = 2'b00,
      PKT_L  = 2'b01,
      PKT_S  = 2'b10,
      PKT_SG = 2'b11
   } pkt_type_e;

   // AXI write-side protocol state
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_RESP = 2'd2
   } wr_state_e;

   localparam int TAG_W       = 4;
   localparam int SEQ_W       = 2;

   // Header field positions inside beat 0 of WDATA
   localparam int HDR_TYPE_LO = 126;
   localparam int HDR_SEQ_LO  = 124;
   localparam int HDR_TAG_LO  = 120;

   localparam logic [1:0] BRESP_OKAY   = 2'b00;
   localparam logic [1:0] BRESP_SLVERR = 2'b10;

   // Packet opens a message
   function automatic logic pkt_som(input pkt_type_e t);
      return (t == PKT_S) || (t == PKT_SG);
   endfunction

   // Packet closes a message
   function automatic logic pkt_eom(input pkt_type_e t);
      return (t == PKT_L) || (t == PKT_SG);
   endfunction

endpackage

// File: rtl/mctp_asm_check.sv
// MCTP packet assembly-order checker. Tracks whether a message is open, the
// expected sequence number and the message tag, and decides on beat 0 of each
// burst whether the packet is accepted (pass) and whether an open message is
// being discarded (abort). State advances only when update is asserted.
module mctp_asm_check
   import mctp_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             update,
   input  pkt_type_e        pkt_type,
   input  logic [SEQ_W-1:0] seq,
   input  logic [TAG_W-1:0] tag,
   output logic             pass,
   output logic             abort
);

   logic             in_msg;
   logic             nxt_in_msg;
   logic [SEQ_W-1:0] exp_seq;
   logic [SEQ_W-1:0] nxt_exp_seq;
   logic [TAG_W-1:0] cur_tag;
   logic [TAG_W-1:0] nxt_cur_tag;

   // Decide acceptance of the current header and compute the next assembly state
   always_comb begin
      pass        = 1'b0;
      abort       = 1'b0;
      nxt_in_msg  = in_msg;
      nxt_exp_seq = exp_seq;
      nxt_cur_tag = cur_tag;
      case (pkt_type)
         PKT_S: begin
            pass        = 1'b1;
            abort       = in_msg;
            nxt_in_msg  = 1'b1;
            nxt_cur_tag = tag;
            nxt_exp_seq = seq + SEQ_W'(1);
         end
         PKT_SG: begin
            pass       = 1'b1;
            abort      = in_msg;
            nxt_in_msg = 1'b0;
         end
         default: begin
            if (in_msg && (seq == exp_seq) && (tag == cur_tag)) begin
               pass        = 1'b1;
               nxt_exp_seq = exp_seq + SEQ_W'(1);
               if (pkt_type == PKT_L) nxt_in_msg = 1'b0;
            end else begin
               abort      = in_msg;
               nxt_in_msg = 1'b0;
            end
         end
      endcase
   end

   // Commit the assembly state once per burst, on the header beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_msg  <= 1'b0;
         exp_seq <= '0;
         cur_tag <= '0;
      end else if (update) begin
         in_msg  <= nxt_in_msg;
         exp_seq <= nxt_exp_seq;
         cur_tag <= nxt_cur_tag;
      end
   end

endmodule

// File: rtl/axi_mctp_wr_slave.sv
// AXI4 write-channel responder for MCTP-over-PCIe VDM writes (256b data).
// One AW/W burst at a time; beat 0 carries the 128b TLP header. Accepted
// packets are forwarded on a valid/ready payload stream through a single
// output register; B returns OKAY or SLVERR.
// Optional statistics counters: define AXI_MCTP_WR_SLV_STATS_EN.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, is held with its data stable until ready.
module axi_mctp_wr_slave
   import mctp_pkg::*;
#(
   parameter int ID_W   = 7,
   parameter int DATA_W = 256
)(
   input  logic                i_clk,
   input  logic                i_reset_n,
   input  logic [ID_W-1:0]     I_AWID,
   input  logic [63:0]         I_AWADDR,
   input  logic [7:0]          I_AWLEN,
   input  logic                I_AWVALID,
   output logic                O_AWREADY,
   input  logic [DATA_W-1:0]   I_WDATA,
   input  logic [DATA_W/8-1:0] I_WSTRB,
   input  logic                I_WLAST,
   input  logic                I_WVALID,
   output logic                O_WREADY,
   output logic [ID_W-1:0]     O_BID,
   output logic [1:0]          O_BRESP,
   output logic                O_BVALID,
   input  logic                I_BREADY,
   output logic [DATA_W-1:0]   O_PDATA,
   output logic                O_PSOF,
   output logic                O_PEOF,
   output logic                O_PSOM,
   output logic                O_PEOM,
   output logic                O_PVALID,
   input  logic                I_PREADY,
`ifdef AXI_MCTP_WR_SLV_STATS_EN
   output logic [31:0]         O_STAT_MSG_OK,
   output logic [31:0]         O_STAT_ERR,
`endif
   output logic                O_ABORT
);

   wr_state_e   state;
   logic [7:0]  awlen_q;
   logic [63:0] awaddr_q;
   logic [7:0]  beat_cnt;
   logic        err_q;
   logic        fwd_q;
   pkt_type_e   type_q;

   logic        wfire;
   logic        beat0;
   logic        last_beat;
   pkt_type_e   hdr_type;
   pkt_type_e   cur_type;
   logic        chk_pass;
   logic        chk_abort;
   logic        fwd_beat;
   logic        beat_err;
   logic        unused_addr;

   // The address is captured for completeness but never decoded
   assign unused_addr = ^awaddr_q;

   // W is accepted only while the payload register can take a beat
   assign O_WREADY  = (state == ST_DATA) && (!O_PVALID || I_PREADY);
   assign wfire     = O_WREADY && I_WVALID;
   assign beat0     = (beat_cnt == 8'd0);
   assign last_beat = (beat_cnt == awlen_q);
   assign hdr_type  = pkt_type_e'(I_WDATA[HDR_TYPE_LO +: 2]);
   assign cur_type  = beat0 ? hdr_type : type_q;
   assign fwd_beat  = beat0 ? chk_pass : fwd_q;
   assign beat_err  = (I_WSTRB != '1) || (I_WLAST != last_beat) || (beat0 && !chk_pass);

   mctp_asm_check u_asm_check (
      .clk      (i_clk),
      .rst_n    (i_reset_n),
      .update   (wfire && beat0),
      .pkt_type (hdr_type),
      .seq      (I_WDATA[HDR_SEQ_LO +: SEQ_W]),
      .tag      (I_WDATA[HDR_TAG_LO +: TAG_W]),
      .pass     (chk_pass),
      .abort    (chk_abort)
   );

   // AXI protocol FSM with registered AW ready, B channel and abort pulse
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state     <= ST_IDLE;
         O_AWREADY <= 1'b0;
         O_BVALID  <= 1'b0;
         O_BRESP   <= BRESP_OKAY;
         O_BID     <= '0;
         O_ABORT   <= 1'b0;
         awlen_q   <= '0;
         awaddr_q  <= '0;
         beat_cnt  <= '0;
         err_q     <= 1'b0;
         fwd_q     <= 1'b0;
         type_q    <= PKT_M;
      end else begin
         O_ABORT <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (O_AWREADY && I_AWVALID) begin
                  O_AWREADY <= 1'b0;
                  O_BID     <= I_AWID;
                  awlen_q   <= I_AWLEN;
                  awaddr_q  <= I_AWADDR;
                  beat_cnt  <= '0;
                  err_q     <= 1'b0;
                  state     <= ST_DATA;
               end else begin
                  O_AWREADY <= 1'b1;
               end
            end
            ST_DATA: begin
               if (wfire) begin
                  beat_cnt <= beat_cnt + 8'd1;
                  err_q    <= err_q || beat_err;
                  if (beat0) begin
                     fwd_q   <= chk_pass;
                     type_q  <= hdr_type;
                     O_ABORT <= chk_abort;
                  end
                  // The burst length is set by AWLEN, not by WLAST
                  if (last_beat) begin
                     O_BVALID <= 1'b1;
                     O_BRESP  <= (err_q || beat_err) ? BRESP_SLVERR : BRESP_OKAY;
                     state    <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               if (I_BREADY) begin
                  O_BVALID  <= 1'b0;
                  O_AWREADY <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Payload output register: loads a forwarded beat, empties when taken
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         O_PVALID <= 1'b0;
         O_PDATA  <= '0;
         O_PSOF   <= 1'b0;
         O_PEOF   <= 1'b0;
         O_PSOM   <= 1'b0;
         O_PEOM   <= 1'b0;
      end else if (wfire && fwd_beat) begin
         O_PVALID <= 1'b1;
         O_PDATA  <= I_WDATA;
         O_PSOF   <= beat0;
         O_PEOF   <= last_beat;
         O_PSOM   <= beat0 && pkt_som(cur_type);
         O_PEOM   <= last_beat && pkt_eom(cur_type);
      end else if (I_PREADY) begin
         O_PVALID <= 1'b0;
      end
   end

`ifdef AXI_MCTP_WR_SLV_STATS_EN
   // Saturating counters: completed messages forwarded and SLVERR responses
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         O_STAT_MSG_OK <= '0;
         O_STAT_ERR    <= '0;
      end else begin
         if (wfire && beat0 && chk_pass && pkt_eom(hdr_type) && (O_STAT_MSG_OK != '1))
            O_STAT_MSG_OK <= O_STAT_MSG_OK + 32'd1;
         if ((state == ST_DATA) && wfire && last_beat && (err_q || beat_err) && (O_STAT_ERR != '1))
            O_STAT_ERR <= O_STAT_ERR + 32'd1;
      end
   end
`endif

endmodule
